// File: rtl/upg_loader.sv
// UART program-upload sequencer: parses a 16-bit word count, then packs the bytes that
// follow little-endian into 32-bit words and writes them into the program ROM.
module upg_loader #(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 10_000_000
) (
  input  logic              upg_clk_i,
  input  logic              upg_rst_n_i,
  input  logic              start_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i,
  output logic              upg_wen_o,
  output logic [ADDR_W-1:0] upg_adr_o,
  output logic [31:0]       upg_dat_o,
  output logic              upg_done_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_o
);

  localparam int            TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]   CAP  = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       buf_q, buf_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic [15:0] len_new;
  logic        last_wr;
  logic        tmo;

  assign len_new = {rx_data_i, len_q[7:0]};
  // The final word's write cycle is where the session completes.
  assign last_wr = wen_q && ((32'(words_q) + 32'd1) == 32'(len_q));

  always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
    if (!upg_rst_n_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      bidx_q  <= '0;
      buf_q   <= '0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      buf_q   <= buf_d;
      wen_q   <= wen_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      words_q <= words_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    buf_d   = buf_q;
    wen_d   = 1'b0;
    adr_d   = adr_q;
    dat_d   = dat_q;
    done_d  = done_q;
    busy_d  = busy_q;
    err_d   = err_q;
    words_d = wen_q ? words_q + 1'b1 : words_q;
    tcnt_d  = tcnt_q;
    tmo     = 1'b0;

    // Byte watchdog, active only while a session is open.
    if (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA) begin
      if (rx_valid_i)            tcnt_d = '0;
      else if (tcnt_q == TMAX)   tmo    = 1'b1;
      else                       tcnt_d = tcnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          state_d = LEN_LO;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          words_d = '0;
          bidx_d  = '0;
          tcnt_d  = '0;
        end
      end
      LEN_LO: begin
        if (rx_valid_i) begin
          len_d[7:0] = rx_data_i;
          state_d    = LEN_HI;
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      LEN_HI: begin
        if (rx_valid_i) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (32'(len_new) > CAP) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      DATA: begin
        if (last_wr) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (rx_valid_i) begin
          unique case (bidx_q)
            2'd0: buf_d[7:0]   = rx_data_i;
            2'd1: buf_d[15:8]  = rx_data_i;
            2'd2: buf_d[23:16] = rx_data_i;
            default: begin
              wen_d = 1'b1;
              dat_d = {rx_data_i, buf_q};
              adr_d = words_q[ADDR_W-1:0];
            end
          endcase
          bidx_d = bidx_q + 1'b1;
        end else if (tmo) begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != ERR && state_d == ERR) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign busy_o     = busy_q;
  assign err_o      = err_q;
  assign words_o    = words_q;

endmodule

// File: tb/tb_upg_loader.sv
// Randomized scoreboard bench for upg_loader: a byte-list reference model predicts ROM writes,
// a negedge monitor pops and compares each write pulse.
module tb_upg_loader;
  localparam int ADDR_W = 14;
  localparam int TMO    = 100;
  localparam int CAP    = 1 << ADDR_W;

  logic              gclk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wen;
  logic [ADDR_W-1:0] adr;
  logic [31:0]       dat;
  logic              done, busy, err;
  logic [ADDR_W:0]   words;

  typedef struct packed {
    logic [ADDR_W-1:0] adr;
    logic [31:0]       dat;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] bs[$];
  int         vectors = 0;
  int         miscomp = 0;

  always #5 gclk = ~gclk;

  upg_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .upg_clk_i(gclk), .upg_rst_n_i(rst_n), .start_i(start),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
    .upg_done_o(done), .busy_o(busy), .err_o(err), .words_o(words)
  );

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscomp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: every complete 4-byte group after a legal header is one write, little-endian.
  task automatic model(input logic [7:0] s[$]);
    int len;
    wr_t w;
    len = {s[1], s[0]};
    if (len == 0 || len > CAP) return;
    for (int i = 0; i < len; i++) begin
      if (2 + 4*i + 3 >= s.size()) break;
      w.adr = ADDR_W'(i);
      w.dat = {s[2+4*i+3], s[2+4*i+2], s[2+4*i+1], s[2+4*i]};
      exp_q.push_back(w);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge gclk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] s[$], input int gmax);
    for (int i = 0; i < s.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = s[i];
      step(1);
      rx_valid = 1'b0;
      if (i != s.size() - 1) step($urandom_range(0, gmax));
    end
  endtask

  always @(negedge gclk) begin
    if (rst_n && wen) begin
      wr_t e;
      vectors++;
      if (exp_q.size() == 0) begin
        miscomp++;
        $display("FAIL unexpected_wen: got adr=%0h dat=%0h expected no write", adr, dat);
      end else begin
        e = exp_q.pop_front();
        if (adr !== e.adr || dat !== e.dat) begin
          miscomp++;
          $display("FAIL wen_data: got adr=%0h dat=%0h expected adr=%0h dat=%0h",
                   adr, dat, e.adr, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0;
    #12;
    chk("rst_done", done, 1); chk("rst_busy", busy, 0); chk("rst_wen", wen, 0);
    chk("rst_err", err, 0); chk("rst_words", words, 0);
    chk("rst_adr", adr, 0); chk("rst_dat", dat, 0);
    @(posedge gclk); #1 rst_n = 1'b1;
    step(2);

    // normal load
    bs = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    model(bs);
    pulse_start();
    chk("start_busy", busy, 1); chk("start_done", done, 0); chk("start_words", words, 0);
    send(bs, 2);
    chk("last_wen", wen, 1); chk("pre_done", done, 0);
    step(1);
    chk("norm_done", done, 1); chk("norm_busy", busy, 0); chk("norm_words", words, 2);
    chk("norm_drain", exp_q.size(), 0);

    // back-to-back
    bs = '{8'h03, 8'h00};
    for (int i = 0; i < 12; i++) bs.push_back(8'(i));
    model(bs);
    pulse_start();
    send(bs, 0);
    step(1);
    chk("b2b_done", done, 1); chk("b2b_words", words, 3); chk("b2b_drain", exp_q.size(), 0);

    // empty
    pulse_start();
    bs = '{8'h00, 8'h00};
    send(bs, 0);
    chk("empty_done", done, 1); chk("empty_busy", busy, 0); chk("empty_words", words, 0);

    // oversize
    pulse_start();
    bs = '{8'h01, 8'h40};
    send(bs, 0);
    chk("over_err", err, 1); chk("over_done", done, 0); chk("over_busy", busy, 0);
    bs = '{8'h55};
    send(bs, 0);
    step(3);
    chk("over_hold_err", err, 1); chk("over_hold_words", words, 0);

    // exactly full capacity accepted
    pulse_start();
    chk("full_clr_err", err, 0);
    bs = '{8'h00, 8'h40};
    send(bs, 0);
    step(5);
    chk("full_busy", busy, 1); chk("full_err", err, 0); chk("full_done", done, 0);
    @(posedge gclk); #2 rst_n = 1'b0;
    step(1); rst_n = 1'b1;
    step(1);

    // timeout
    bs = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    model(bs);
    pulse_start();
    send(bs, 0);
    step(TMO - 1);
    chk("tmo_early_err", err, 0); chk("tmo_early_busy", busy, 1);
    step(1);
    chk("tmo_err", err, 1); chk("tmo_busy", busy, 0); chk("tmo_done", done, 0);

    // retry
    pulse_start();
    chk("retry_err", err, 0);
    bs = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    model(bs);
    send(bs, 1);
    step(1);
    chk("retry_done", done, 1); chk("retry_words", words, 1); chk("retry_drain", exp_q.size(), 0);

    // start ignored mid-word
    bs = '{8'h01, 8'h00, 8'h55, 8'h66, 8'h77, 8'h88};
    model(bs);
    pulse_start();
    bs = '{8'h01, 8'h00, 8'h55, 8'h66};
    send(bs, 0);
    pulse_start();
    chk("ign_busy", busy, 1); chk("ign_words", words, 0); chk("ign_err", err, 0);
    bs = '{8'h77, 8'h88};
    send(bs, 0);
    step(1);
    chk("ign_done", done, 1); chk("ign_total", words, 1); chk("ign_drain", exp_q.size(), 0);

    // async reset mid-word: no write
    pulse_start();
    bs = '{8'h01, 8'h00, 8'h99, 8'hAA};
    send(bs, 0);
    @(posedge gclk); #2 rst_n = 1'b0;
    #1;
    chk("mrst_done", done, 1); chk("mrst_busy", busy, 0); chk("mrst_wen", wen, 0);
    chk("mrst_words", words, 0);
    step(1); rst_n = 1'b1;
    step(3);
    chk("mrst_after_done", done, 1);

    // randomized sessions
    for (int n = 0; n < 20; n++) begin
      len = $urandom_range(1, 5);
      bs = '{8'(len), 8'h00};
      for (int i = 0; i < 4*len; i++) bs.push_back(8'($urandom));
      model(bs);
      pulse_start();
      send(bs, 2);
      step(1);
      chk("rnd_done", done, 1); chk("rnd_words", words, 48'(len)); chk("rnd_err", err, 0);
    end
    step(2);
    chk("final_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscomp);
    $finish;
  end
endmodule
